// File: rtl/seq_detector_param.sv
// seq_detector_param: programmable serial pattern detector with overlap control and saturating match counter
module seq_detector_param #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               pattern_ld,
  input  logic               overlap,
  input  logic               clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  logic [PAT_LEN-1:0] pat_r, hist, hist_n;
  logic [FW-1:0] fill, fill_n;
  logic match;
  always_comb begin
    hist_n = {hist[PAT_LEN-2:0], in};
    fill_n = (fill == FULL) ? fill : fill + 1'b1;
    match  = (fill_n == FULL) && (hist_n == pat_r);
  end
  assign cnt_sat = &match_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_r     <= '0;
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
    end else if (clr) begin
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
    end else if (pattern_ld) begin
      pat_r <= pattern;
      hist  <= '0;
      fill  <= '0;
      out   <= 1'b0;
    end else if (in_valid) begin
      hist <= hist_n;
      out  <= match;
      // non-overlapping mode restarts the fill so a fresh PAT_LEN bits are needed
      fill <= (match && !overlap) ? '0 : fill_n;
      if (match && !cnt_sat) match_cnt <= match_cnt + 1'b1;
    end else begin
      out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed self-checking bench for seq_detector_param
module tb_seq_detector_param;
  logic clk = 0, rst = 0, in = 0, in_valid = 0, pattern_ld = 0, overlap = 0, clr = 0;
  logic [3:0] pat4 = '0;
  logic [1:0] pat2 = '0;
  logic out4, out2, sat4, sat2;
  logic [7:0] cnt4;
  logic [1:0] cnt2;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  seq_detector_param #(.PAT_LEN(4), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pattern(pat4),
    .pattern_ld(pattern_ld), .overlap(overlap), .clr(clr),
    .out(out4), .match_cnt(cnt4), .cnt_sat(sat4)
  );
  seq_detector_param #(.PAT_LEN(2), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pattern(pat2),
    .pattern_ld(pattern_ld), .overlap(overlap), .clr(clr),
    .out(out2), .match_cnt(cnt2), .cnt_sat(sat2)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic b, input logic v);
    in = b;
    in_valid = v;
    @(posedge clk);
    #1;
    in_valid = 0;
    in = 0;
  endtask
  task automatic pulse_clr();
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
  endtask
  task automatic load(input logic [3:0] p4, input logic [1:0] p2, input logic b);
    pat4 = p4;
    pat2 = p2;
    pattern_ld = 1;
    in = b;
    in_valid = 1;
    @(posedge clk);
    #1;
    pattern_ld = 0;
    in_valid = 0;
    in = 0;
  endtask
  task automatic stream4(input string tag, input logic [15:0] bits, input logic [15:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      tick(bits[n-1-i], 1'b1);
      check($sformatf("%s_bit%0d", tag, i + 1), {31'b0, out4}, {31'b0, exp[n-1-i]});
    end
  endtask
  initial begin
    #3;
    check("rst_out", {31'b0, out4}, 0);
    check("rst_cnt", {24'b0, cnt4}, 0);
    check("rst_sat", {31'b0, sat4}, 0);
    @(negedge clk);
    rst = 1;
    load(4'b1011, 2'b11, 1'b0);
    overlap = 1;
    stream4("ovl", 16'b1011011, 16'b0001001, 7);
    check("ovl_cnt", {24'b0, cnt4}, 2);
    pulse_clr();
    check("clr_cnt", {24'b0, cnt4}, 0);
    overlap = 0;
    stream4("novl_a", 16'b1011011, 16'b0001000, 7);
    check("novl_a_cnt", {24'b0, cnt4}, 1);
    pulse_clr();
    stream4("novl_b", 16'b1011011011, 16'b0001000001, 10);
    check("novl_b_cnt", {24'b0, cnt4}, 2);
    pulse_clr();
    overlap = 1;
    for (int i = 0; i < 4; i++) begin
      tick(i != 1, 1'b1);
      check($sformatf("gap_bit%0d", i + 1), {31'b0, out4}, {31'b0, i == 3});
      for (int j = 0; j < 3; j++) begin
        tick(1'b1, 1'b0);
        check($sformatf("gap_idle%0d_%0d", i + 1, j), {31'b0, out4}, 0);
      end
    end
    check("gap_cnt", {24'b0, cnt4}, 1);
    pulse_clr();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1);
      check($sformatf("sat_out%0d", i + 1), {31'b0, out2}, {31'b0, i > 0});
    end
    check("sat_cnt", {30'b0, cnt2}, 3);
    check("sat_flag", {31'b0, sat2}, 1);
    pulse_clr();
    check("sat_clr_cnt", {30'b0, cnt2}, 0);
    check("sat_clr_flag", {31'b0, sat2}, 0);
    stream4("rl_pre", 16'b101, 16'b000, 3);
    load(4'b0110, 2'b11, 1'b1);
    check("rl_ld_out", {31'b0, out4}, 0);
    stream4("rl_post", 16'b0110, 16'b0001, 4);
    check("rl_cnt", {24'b0, cnt4}, 1);
    stream4("rs_pre", 16'b0110101, 16'b0001000, 7);
    check("rs_pre_cnt", {24'b0, cnt4}, 2);
    #2;
    rst = 0;
    #1;
    check("rs_async_out", {31'b0, out4}, 0);
    check("rs_async_cnt", {24'b0, cnt4}, 0);
    check("rs_async_cnt2", {30'b0, cnt2}, 0);
    @(negedge clk);
    rst = 1;
    load(4'b1011, 2'b11, 1'b0);
    stream4("rs_trail", 16'b1, 16'b0, 1);
    stream4("rs_full", 16'b1011, 16'b0001, 4);
    check("rs_cnt", {24'b0, cnt4}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector with a runtime-programmable pattern, selectable overlapping/non-overlapping detection, an input qualifier and a saturating match counter. It generalises the fixed 2-bit-state Moore detector to any pattern length `PAT_LEN`. It sits on a serial data path after the bit-recovery logic and flags every occurrence of the loaded pattern to downstream control.

## Interface
Parameters:
- `PAT_LEN`, default 4: pattern length in bits; legal range 2..32.
- `CNT_W`, default 8: match counter width; legal range 1..32.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in`  in  1  serial data bit.
- `in_valid`  in  1  qualifies `in`. `in` is consumed only on edges where `in_valid` = 1.
- `pattern`  in  PAT_LEN  new pattern value. `pattern[PAT_LEN-1]` is the first bit received and `pattern[0]` is the last.
- `pattern_ld`  in  1  latches `pattern` into the internal pattern register.
- `overlap`  in  1  1 = overlapping detection; 0 = non-overlapping. Sampled every accepted bit.
- `clr`  in  1  synchronous clear of the counter and the detection history.
- `out`  out  1  registered match pulse.
- `match_cnt`  out  CNT_W  saturating count of matches.
- `cnt_sat`  out  1  high while `match_cnt` is at its maximum (all ones).

## Operation
Internal state:
- `pat_r`: PAT_LEN-bit pattern register.
- `hist`: PAT_LEN-bit shift history.
- `fill`: counter from 0 to PAT_LEN, saturating at PAT_LEN.
- `out`.
- `match_cnt`.

Reset (`rst` = 0), asynchronous:
- `pat_r` = all zeros, `hist` = 0, `fill` = 0.
- `out` = 0, `match_cnt` = 0, `cnt_sat` = 0.
- Takes effect immediately, including in the middle of a pattern. No match is ever reported from bits received before reset.

Per rising edge, evaluated in strict priority order:
1. `clr` = 1: `hist` = 0, `fill` = 0, `match_cnt` = 0, `out` = 0. `pat_r` is unchanged. `in_valid` and `pattern_ld` are ignored.
2. `pattern_ld` = 1: `pat_r` = `pattern`, `hist` = 0, `fill` = 0, `out` = 0. The bit on `in`, if any, is discarded.
3. `in_valid` = 1:
   - `hist_n` = {hist[PAT_LEN-2:0], in}.
   - `fill_n` = min(fill+1, PAT_LEN).
   - `match` = (`fill_n` == PAT_LEN) && (`hist_n` == `pat_r`).
   - `hist` = `hist_n`.
   - `out` = `match`.
   - If `match` && `overlap` = 0: `fill` = 0. Otherwise `fill` = `fill_n`.
   - If `match` && `match_cnt` != all-ones: `match_cnt` increments by 1.
4. Otherwise (idle edge): `out` = 0 and all other state holds.

Detection rules:
- Overlapping mode: the bits of a completed match can be the prefix of the next match.
- Non-overlapping mode: a fresh PAT_LEN bits must be received after each match before another match can occur.
- `cnt_sat` = &`match_cnt`, combinational from the register.

## Timing
- Latency: `out` goes high on the edge that accepts the final pattern bit. It is visible for exactly one clock cycle after that edge.
- Consecutive matches on back-to-back valid bits produce back-to-back `out` pulses. In overlapping mode this happens only when the pattern is all 0s or all 1s.
- `in_valid` gaps: `out` drops to 0 on the next edge. Partial history is preserved across gaps of any length.
- `match_cnt` updates on the same edge as `out`.
- Counter saturation: once saturated, `match_cnt` holds at all-ones. `out` still pulses on each further match.
- Changing `overlap` mid-stream takes effect on the next accepted bit. A pending match is not cancelled.
- The first match after reset, `clr` or `pattern_ld` needs at least PAT_LEN accepted bits.

## Test plan
1. Overlapping detection. Setup: PAT_LEN=4, load 1011, `overlap`=1. Stimulus: stream 1,0,1,1,0,1,1 with `in_valid` held high. Required: `out` pulses after bits 4 and 7; `match_cnt` = 2.
2. Non-overlapping detection. Setup: same pattern, `overlap`=0. Stimulus: stream 1,0,1,1,0,1,1. Required: a single pulse after bit 4. Then stimulus 1,0,1,1,0,1,1,0,1,1. Required: pulses after bits 4 and 10.
3. Valid gaps. Stimulus: 1011 delivered with `in_valid` low for 3 cycles between each bit. Required: one pulse, exactly one cycle wide, in the cycle after the 4th accepted bit.
4. Saturation and clear. Setup: CNT_W=2, pattern 11, `overlap`=1. Stimulus: 6 consecutive 1s. Required: 5 `out` pulses; `match_cnt` sticks at 3; `cnt_sat` = 1. Then `clr`. Required: `match_cnt` = 0 and `cnt_sat` = 0 on the next cycle.
5. Pattern reload mid-stream. Stimulus: feed 101, then pulse `pattern_ld` with 0110 while `in_valid` = 1 and `in` = 1, then feed 0110. Required: no pulse from the discarded bit or the old history; one pulse after the 4th post-load bit.
6. Reset in the middle of a pattern. Stimulus: feed 101, assert `rst` low between clock edges, release it, reload 1011, then feed 1. Required: all outputs go to 0 immediately on reset assertion; no pulse after the trailing 1. A full 1011 afterwards gives exactly one pulse.
